sensor_packet_parser: RTL

Receives the AXI-Stream packet stream produced by the sensor acquisition block and checks its framing. Each frame is HEADER, TIME_STAMP, payload, FOOTER. The block extracts the timestamp and either the processed accumulators (c_acc, d_acc) or the raw payload words. It sits on the consumer side of the `data` stream, in loopback test fabric or ahead of the DMA/host path, and reports frame and sequence events plus saturating error counters.

---
 rtl/sensor_packet_parser.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/sensor_packet_parser.sv
// sensor_packet_parser: framing checker for the sensor acquisition stream.
// Extracts timestamp, accumulators or raw words and counts framing errors.
module sensor_packet_parser #(
  parameter int unsigned RAW_WORDS    = 512,
  parameter logic [31:0] HEADER_VALUE = 32'hAAAAAAAA,
  parameter logic [31:0] FOOTER_VALUE = 32'h55555555
) (
  input  logic        master_clock,
  input  logic        resetn,
  input  logic        expect_raw_data,
  input  logic [31:0] data_tdata,
  input  logic        data_tvalid,
  input  logic        data_tlast,
  output logic        data_tready,
  output logic        frame_valid,
  output logic        frame_raw,
  output logic [31:0] frame_timestamp,
  output logic [47:0] frame_c_acc,
  output logic [47:0] frame_d_acc,
  output logic        seq_done,
  output logic [15:0] frame_count,
  output logic [31:0] raw_tdata,
  output logic        raw_tvalid,
  output logic        raw_tlast,
  output logic [15:0] sync_err_count,
  output logic [15:0] frame_err_count,
  output logic [2:0]  dbg_state
);

  localparam int unsigned CW =
    (RAW_WORDS > 4) ? $clog2(RAW_WORDS) : 2;
  localparam logic [CW-1:0] RAW_LAST  = CW'(RAW_WORDS - 1);
  localparam logic [CW-1:0] PROC_LAST = CW'(2);

  typedef enum logic [2:0] {
    SEEK_HDR = 3'd0,
    TSTAMP   = 3'd1,
    PAY_PROC = 3'd2,
    PAY_RAW  = 3'd3,
    CHK_FTR  = 3'd4
  } state_t;

  state_t st, st_nxt;

  logic          beat;
  logic          sync_inc;
  logic          ferr_inc;
  logic          good;
  logic          cap_ts;
  logic          cap_w;
  logic          fwd;
  logic [CW-1:0] wcnt;
  logic          mode;
  logic [31:0]   ts_sh;
  logic [47:0]   c_sh;
  logic [47:0]   d_sh;

  assign beat      = data_tvalid & data_tready;
  assign dbg_state = st;

  always_ff @(posedge master_clock or negedge resetn) begin
    if (!resetn) begin
      st <= SEEK_HDR;
    end else begin
      st <= st_nxt;
    end
  end

  // tlast outside the footer slot aborts the frame whatever the state
  always_comb begin
    st_nxt   = st;
    sync_inc = 1'b0;
    ferr_inc = 1'b0;
    good     = 1'b0;
    cap_ts   = 1'b0;
    cap_w    = 1'b0;
    fwd      = 1'b0;
    if (beat) begin
      if (data_tlast && st != CHK_FTR) begin
        ferr_inc = 1'b1;
        st_nxt   = SEEK_HDR;
      end else begin
        unique case (st)
          SEEK_HDR: begin
            if (data_tdata == HEADER_VALUE) begin
              st_nxt = TSTAMP;
            end else begin
              sync_inc = 1'b1;
            end
          end
          TSTAMP: begin
            cap_ts = 1'b1;
            st_nxt = expect_raw_data ? PAY_RAW : PAY_PROC;
          end
          PAY_PROC: begin
            cap_w = 1'b1;
            if (wcnt == PROC_LAST) begin
              st_nxt = CHK_FTR;
            end
          end
          PAY_RAW: begin
            fwd = 1'b1;
            if (wcnt == RAW_LAST) begin
              st_nxt = CHK_FTR;
            end
          end
          CHK_FTR: begin
            if (data_tdata == FOOTER_VALUE) begin
              good   = 1'b1;
              st_nxt = SEEK_HDR;
            end else begin
              ferr_inc = 1'b1;
              st_nxt   = (data_tdata == HEADER_VALUE) ? TSTAMP : SEEK_HDR;
            end
          end
          default: st_nxt = SEEK_HDR;
        endcase
      end
    end
  end

  always_ff @(posedge master_clock or negedge resetn) begin
    if (!resetn) begin
      data_tready <= 1'b0;
    end else begin
      data_tready <= 1'b1;
    end
  end

  always_ff @(posedge master_clock or negedge resetn) begin
    if (!resetn) begin
      wcnt  <= '0;
      mode  <= 1'b0;
      ts_sh <= '0;
      c_sh  <= '0;
      d_sh  <= '0;
    end else begin
      if (cap_ts) begin
        wcnt  <= '0;
        mode  <= expect_raw_data;
        ts_sh <= data_tdata;
      end else if (cap_w || fwd) begin
        wcnt <= wcnt + CW'(1);
      end
      if (cap_w) begin
        if (wcnt == '0) begin
          c_sh[31:0] <= data_tdata;
        end else if (wcnt == CW'(1)) begin
          c_sh[47:32] <= data_tdata[15:0];
          d_sh[15:0]  <= data_tdata[31:16];
        end else begin
          d_sh[47:16] <= data_tdata;
        end
      end
    end
  end

  always_ff @(posedge master_clock or negedge resetn) begin
    if (!resetn) begin
      raw_tdata  <= '0;
      raw_tvalid <= 1'b0;
      raw_tlast  <= 1'b0;
    end else begin
      raw_tvalid <= fwd;
      raw_tlast  <= fwd && (wcnt == RAW_LAST);
      if (fwd) begin
        raw_tdata <= data_tdata;
      end
    end
  end

  always_ff @(posedge master_clock or negedge resetn) begin
    if (!resetn) begin
      frame_valid     <= 1'b0;
      seq_done        <= 1'b0;
      frame_raw       <= 1'b0;
      frame_timestamp <= '0;
      frame_c_acc     <= '0;
      frame_d_acc     <= '0;
    end else begin
      frame_valid <= good;
      seq_done    <= good & data_tlast;
      if (good) begin
        frame_raw       <= mode;
        frame_timestamp <= ts_sh;
        if (!mode) begin
          frame_c_acc <= c_sh;
          frame_d_acc <= d_sh;
        end
      end
    end
  end

  // seq_done is high for exactly one cycle, so it doubles as the clear
  always_ff @(posedge master_clock or negedge resetn) begin
    if (!resetn) begin
      frame_count     <= '0;
      sync_err_count  <= '0;
      frame_err_count <= '0;
    end else begin
      if (seq_done) begin
        frame_count <= '0;
      end else if (good) begin
        frame_count <= frame_count + 16'd1;
      end
      if (sync_inc && sync_err_count != 16'hFFFF) begin
        sync_err_count <= sync_err_count + 16'd1;
      end
      if (ferr_inc && frame_err_count != 16'hFFFF) begin
        frame_err_count <= frame_err_count + 16'd1;
      end
    end
  end

endmodule
